// File: rtl/my_led_pwm.sv
// rtl/my_led_pwm.sv - Avalon-MM LED bank with set/clear, 8-bit PWM dimming and blink (PWM gated by MY_LED_PWM_PWM_EN)
module my_led_pwm #(
    parameter int WIDTH     = 10,
    parameter int BLINK_DIV = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] LED_out
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_SET  = 2'd1;
    localparam logic [1:0] ADDR_CLR  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;
    localparam logic [7:0] PERIOD_LAST = 8'd254;
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             blink_en_q, blink_en_d;
    logic             phase_q, phase_d;
    logic [7:0]       period_q, period_d;
    logic [15:0]      blink_cnt_q, blink_cnt_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [7:0]       duty_rd;
    logic             gate;
    logic             wrap;
    logic             unused_wdata;

`ifdef MY_LED_PWM_PWM_EN
    logic [7:0]       duty_q, duty_d;

    always_comb begin
        duty_d = duty_q;
        if (write && address == ADDR_CTRL) begin
            duty_d = writedata[7:0];
        end
    end

    assign gate    = (period_q < duty_q);
    assign duty_rd = duty_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q <= 8'hFF;
        end else begin
            duty_q <= duty_d;
        end
    end
`else
    assign gate    = 1'b1;
    assign duty_rd = 8'hFF;
`endif

    assign unused_wdata = ^writedata;
    assign wrap         = (period_q == PERIOD_LAST);

    always_comb begin
        period_d = wrap ? 8'd0 : period_q + 8'd1;

        data_d     = data_q;
        blink_en_d = blink_en_q;
        if (write) begin
            case (address)
                ADDR_DATA: data_d = writedata[WIDTH-1:0];
                ADDR_SET:  data_d = data_q | writedata[WIDTH-1:0];
                ADDR_CLR:  data_d = data_q & ~writedata[WIDTH-1:0];
                default:   blink_en_d = writedata[8];
            endcase
        end

        // Disabled (or just enabled) blink parks at phase 1 with an empty half-phase count.
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!blink_en_d || !blink_en_q) begin
            blink_cnt_d = 16'd0;
            phase_d     = 1'b1;
        end else if (wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 16'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end

        led_d = data_q & {WIDTH{gate & phase_q}};

        rdata_d = 32'd0;
        case (address)
            ADDR_DATA: rdata_d[WIDTH-1:0] = data_q;
            ADDR_CTRL: begin
                rdata_d[31]  = phase_q;
                rdata_d[8]   = blink_en_q;
                rdata_d[7:0] = duty_rd;
            end
            default:   rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= '0;
            blink_en_q  <= 1'b0;
            phase_q     <= 1'b1;
            period_q    <= 8'd0;
            blink_cnt_q <= 16'd0;
            led_q       <= '0;
            rdata_q     <= 32'd0;
        end else begin
            data_q      <= data_d;
            blink_en_q  <= blink_en_d;
            phase_q     <= phase_d;
            period_q    <= period_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
            rdata_q     <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign LED_out  = led_q;

endmodule

// File: tb/tb_my_led_pwm.sv
// tb/tb_my_led_pwm.sv - self-checking bench for my_led_pwm (WIDTH=10, BLINK_DIV=2)
module tb_my_led_pwm;

    localparam int W  = 10;
    localparam int BD = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         write = 1'b0;
    logic [31:0]  writedata = 32'd0;
    logic [31:0]  readdata;
    logic [W-1:0] LED_out;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    my_led_pwm #(.WIDTH(W), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .LED_out   (LED_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time since reset, wraps seen while blinking, and the register file.
    logic [W-1:0] m_data = '0;
    logic [7:0]   m_duty = 8'hFF;
    bit           m_ben = 1'b0;
    int           m_cyc = 0;
    int           m_wraps = 0;
    logic [W-1:0] exp_led = '0;
    logic [31:0]  exp_rd = 32'd0;

    function automatic bit m_phase();
        return !m_ben || ((m_wraps / BD) % 2 == 0);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit          gate;
        bit          ph;
        logic [31:0] r;
        if (!reset_n) begin
            m_data  = '0;
            m_duty  = 8'hFF;
            m_ben   = 1'b0;
            m_cyc   = 0;
            m_wraps = 0;
            exp_led = '0;
            exp_rd  = 32'd0;
        end else begin
            ph = m_phase();
`ifdef MY_LED_PWM_PWM_EN
            gate = (int'(m_duty) > (m_cyc % 255));
`else
            gate = 1'b1;
`endif
            exp_led = (gate && ph) ? m_data : '0;
            case (address)
                2'd0:    r = 32'(m_data);
                2'd3:    r = {ph, 22'd0, m_ben, m_duty};
                default: r = 32'd0;
            endcase
            exp_rd = r;
            if (m_ben && (m_cyc % 255 == 254)) m_wraps++;
            if (write) begin
                case (address)
                    2'd0: m_data = writedata[W-1:0];
                    2'd1: m_data = m_data | writedata[W-1:0];
                    2'd2: m_data = m_data & ~writedata[W-1:0];
                    default: begin
`ifdef MY_LED_PWM_PWM_EN
                        m_duty = writedata[7:0];
`endif
                        if (writedata[8] != m_ben) m_wraps = 0;
                        m_ben = writedata[8];
                    end
                endcase
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            check("model_led", 32'(LED_out), 32'(exp_led));
            check("model_rd", readdata, exp_rd);
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        @(negedge clk);
        write     = 1'b0;
        writedata = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        @(negedge clk);
        check(name, readdata, exp);
    endtask

    task automatic count_led(input logic [W-1:0] val, input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (LED_out == val) hits++;
        end
    endtask

    initial begin
        int hits;
        int tt[3];
        int nt;
        logic prev;
        bit found;

        repeat (3) @(negedge clk);
        check("reset_led", 32'(LED_out), 32'd0);
        check("reset_rd", readdata, 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        rd(2'd3, 32'h800000FF, "rd_ctrl_reset");
        rd(2'd0, 32'd0, "rd_data_reset");

        wr(2'd0, 32'hFFFFF2A5);
        check("led_before_latency", 32'(LED_out), 32'd0);
        rd(2'd0, 32'h000002A5, "rd_data_write");
        check("led_after_write", 32'(LED_out), 32'h2A5);

        wr(2'd1, 32'h0000000F);
        wr(2'd2, 32'h00000005);
        rd(2'd0, 32'h000002AA, "rd_data_setclr");
        check("led_setclr", 32'(LED_out), 32'h2AA);
        rd(2'd1, 32'd0, "rd_set_zero");
        rd(2'd2, 32'd0, "rd_clr_zero");
        wr(2'd1, 32'hFFFFFC00);
        rd(2'd0, 32'h000002AA, "rd_upper_ignored");

        wr(2'd0, 32'h3FF);
        wr(2'd3, 32'd64);
        repeat (3) @(negedge clk);
        count_led(10'h3FF, 255, hits);
`ifdef MY_LED_PWM_PWM_EN
        check("pwm64_on", 32'(hits), 32'd64);
        count_led(10'h000, 255, hits);
        check("pwm64_off", 32'(hits), 32'd191);
        rd(2'd3, 32'h80000040, "rd_ctrl_duty64");
`else
        check("pwm64_on", 32'(hits), 32'd255);
        rd(2'd3, 32'h800000FF, "rd_ctrl_duty64");
`endif
        wr(2'd3, 32'd0);
        repeat (3) @(negedge clk);
        count_led(10'h000, 255, hits);
`ifdef MY_LED_PWM_PWM_EN
        check("pwm0_off", 32'(hits), 32'd255);
`else
        check("pwm0_off", 32'(hits), 32'd0);
`endif

        wr(2'd3, 32'h1FF);
        wr(2'd0, 32'h001);
        address = 2'd3;
        @(negedge clk);
        prev = LED_out[0];
        nt = 0;
        for (int i = 0; i < 3000 && nt < 3; i++) begin
            @(negedge clk);
            if (LED_out[0] != prev) begin
                tt[nt] = i;
                nt++;
                prev = LED_out[0];
            end
        end
        check("blink_toggles", 32'(nt), 32'd3);
        if (nt == 3) begin
            check("blink_half1", 32'(tt[1] - tt[0]), 32'd510);
            check("blink_half2", 32'(tt[2] - tt[1]), 32'd510);
        end

        wr(2'd3, 32'h0FF);
        repeat (2) @(negedge clk);
        count_led(10'h001, 600, hits);
        check("blink_off_steady", 32'(hits), 32'd600);

        wr(2'd3, 32'h1FF);
        address = 2'd3;
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            if (LED_out == '0) found = 1'b1;
        end
        check("blink_reach_off", 32'(found), 32'd1);
        @(negedge clk);
        check("rd_ctrl_phase0", readdata, 32'h000001FF);
        #2 reset_n = 1'b0;
        #1;
        check("async_led", 32'(LED_out), 32'd0);
        check("async_rd", readdata, 32'd0);
        repeat (2) @(negedge clk);
        check("held_led", 32'(LED_out), 32'd0);
        reset_n = 1'b1;
        rd(2'd3, 32'h800000FF, "rd_ctrl_after_reset");
        rd(2'd0, 32'd0, "rd_data_after_reset");
        check("led_after_reset", 32'(LED_out), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
